// File: rtl/cache_ctrl_assoc_pkg.sv
// Shared definitions for the set-associative cache controller.
// Holds FSM state encodings, array write-data source encodings and width helpers.
// Pure declarations; no logic, no latency, no backpressure.
package cache_ctrl_assoc_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HIT_DONE  = 3'd1,
      EVICT     = 3'd2,
      FILL      = 3'd3,
      MERGE     = 3'd4,
      MISS_DONE = 3'd5,
      ERR       = 3'd6
   } state_e;

   // Array write data source
   localparam logic DSRC_REQ = 1'b0;
   localparam logic DSRC_MEM = 1'b1;

   // Ceiling log2 for elaboration-time widths
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Index width that never collapses to zero bits
   function automatic int width_of(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/cache_ctrl_assoc_victim_sel.sv
// Victim way selection: lowest-index invalid way, otherwise the set's round-robin pointer.
// Selection is combinational; the pointer table updates one cycle after upd.
// No backpressure; upd is a single-cycle strobe qualified by the controller.
module cache_ctrl_assoc_victim_sel
   import cache_ctrl_assoc_pkg::*;
#(
   parameter  int NUM_WAYS = 2,
   parameter  int NUM_SETS = 256,
   localparam int IDX_W    = width_of(NUM_SETS),
   localparam int WAY_W    = width_of(NUM_WAYS)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_WAYS-1:0] way_valid,
   input  logic [IDX_W-1:0]    idx,
   input  logic                upd,
   output logic [NUM_WAYS-1:0] victim,
   output logic                from_ptr
);

   logic [WAY_W-1:0] ptr_q [NUM_SETS];
   logic [WAY_W-1:0] cur_ptr;
   logic [WAY_W-1:0] ptr_d;

   assign cur_ptr = ptr_q[idx];

   // Pick the lowest invalid way; fall back to the pointer when the set is full
   always_comb begin
      victim   = '0;
      from_ptr = 1'b1;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!way_valid[i]) begin
            victim    = '0;
            victim[i] = 1'b1;
            from_ptr  = 1'b0;
         end
      end
      if (from_ptr) begin
         for (int i = 0; i < NUM_WAYS; i++) begin
            victim[i] = (cur_ptr == WAY_W'(i));
         end
      end
   end

   // Next pointer value wraps at NUM_WAYS (also covers the single-way case)
   always_comb begin
      if (cur_ptr == WAY_W'(NUM_WAYS - 1)) ptr_d = '0;
      else                                 ptr_d = cur_ptr + WAY_W'(1);
   end

   // Round-robin pointer table, one entry per set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) ptr_q[s] <= '0;
      end else if (upd) begin
         ptr_q[idx] <= ptr_d;
      end
   end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative write-back/write-allocate cache controller (optional CACHE_CTRL_PERF_EN counters).
// Hit: done 1 cycle after request; miss: optional evict, pipelined fill, optional merge, then done.
// mem_stall freezes the evict/issue word counters; processor is held on stall until done.
module cache_ctrl_assoc
   import cache_ctrl_assoc_pkg::*;
#(
   parameter  int NUM_WAYS       = 2,
   parameter  int NUM_SETS       = 256,
   parameter  int WORDS_PER_LINE = 4,
   parameter  int MEM_LATENCY    = 2,
   localparam int IDX_W          = width_of(NUM_SETS),
   localparam int OFF_W          = width_of(WORDS_PER_LINE)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_rd,
   input  logic                req_wr,
   input  logic [IDX_W-1:0]    req_index,
   input  logic [OFF_W-1:0]    req_offset,
   input  logic [NUM_WAYS-1:0] way_hit,
   input  logic [NUM_WAYS-1:0] way_valid,
   input  logic [NUM_WAYS-1:0] way_dirty,
   input  logic                cache_err,
   input  logic                mem_err,
   input  logic                mem_stall,
   output logic [NUM_WAYS-1:0] way_sel,
   output logic                cache_comp,
   output logic                cache_write,
   output logic [OFF_W-1:0]    cache_word,
   output logic                data_src,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic [OFF_W-1:0]    mem_word,
   output logic                mem_victim_tag,
   output logic                done,
   output logic                hit,
   output logic                stall,
   output logic                err
`ifdef CACHE_CTRL_PERF_EN
  ,output logic [31:0]         perf_hits,
   output logic [31:0]         perf_misses,
   output logic [31:0]         perf_wbacks
`endif
);

   localparam int              CNT_W = OFF_W + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_LINE - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS_PER_LINE);

   state_e                              state_q, state_d;
   logic [CNT_W-1:0]                    cnt_q, cnt_d;          // evict word / fill issue counter
   logic [CNT_W-1:0]                    ret_cnt_q, ret_cnt_d;  // fill returns written
   logic [NUM_WAYS-1:0]                 victim_q, victim_d;
   logic                                vic_ptr_q, vic_ptr_d;  // victim came from the pointer
   logic [MEM_LATENCY-1:0]              pipe_vld_q, pipe_vld_d;
   logic [MEM_LATENCY-1:0][OFF_W-1:0]   pipe_off_q, pipe_off_d;

   logic                req;
   logic [NUM_WAYS-1:0] hit_vec;
   logic [NUM_WAYS-1:0] hit_onehot;
   logic                any_hit;
   logic                err_in;
   logic                issue;
   logic                ret_vld;
   logic [OFF_W-1:0]    ret_off;
   logic [NUM_WAYS-1:0] vs_victim;
   logic                vs_from_ptr;
   logic                ptr_upd;

   assign req        = req_rd | req_wr;
   assign hit_vec    = way_hit & way_valid;
   assign hit_onehot = hit_vec & (~hit_vec + NUM_WAYS'(1));
   assign any_hit    = |hit_vec;
   assign err_in     = (cache_err | mem_err) & ~((state_q == IDLE) & ~req);
   assign issue      = (state_q == FILL) & (cnt_q != FULL) & ~mem_stall;
   assign ret_vld    = (state_q == FILL) & pipe_vld_q[MEM_LATENCY-1];
   assign ret_off    = pipe_off_q[MEM_LATENCY-1];

   cache_ctrl_assoc_victim_sel #(
      .NUM_WAYS (NUM_WAYS),
      .NUM_SETS (NUM_SETS)
   ) u_victim_sel (
      .clk       (clk),
      .rst       (rst),
      .way_valid (way_valid),
      .idx       (req_index),
      .upd       (ptr_upd),
      .victim    (vs_victim),
      .from_ptr  (vs_from_ptr)
   );

   // Next-state, counters and the read-return tracking pipe
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ret_cnt_d  = ret_cnt_q;
      victim_d   = victim_q;
      vic_ptr_d  = vic_ptr_q;
      ptr_upd    = 1'b0;
      pipe_vld_d = '0;
      pipe_off_d = '0;
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_off_d[i] = pipe_off_q[i-1];
      end
      pipe_vld_d[0] = issue;
      pipe_off_d[0] = cnt_q[OFF_W-1:0];

      case (state_q)
         IDLE: begin
            if (req) begin
               if (any_hit) begin
                  state_d = HIT_DONE;
               end else begin
                  victim_d  = vs_victim;
                  vic_ptr_d = vs_from_ptr;
                  cnt_d     = '0;
                  ret_cnt_d = '0;
                  state_d   = (|(vs_victim & way_valid & way_dirty)) ? EVICT : FILL;
               end
            end
         end
         EVICT: begin
            if (!mem_stall) begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = FILL;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         FILL: begin
            if (issue) cnt_d = cnt_q + CNT_W'(1);
            if (ret_vld) begin
               if (ret_cnt_q == LAST) begin
                  state_d   = req_wr ? MERGE : MISS_DONE;
                  ptr_upd   = vic_ptr_q;
                  cnt_d     = '0;
                  ret_cnt_d = '0;
               end else begin
                  ret_cnt_d = ret_cnt_q + CNT_W'(1);
               end
            end
         end
         MERGE:   state_d = MISS_DONE;
         default: state_d = IDLE;   // HIT_DONE, MISS_DONE, ERR
      endcase

      // Errors abandon the transaction: no pointer update, in-flight reads dropped
      if (err_in) begin
         state_d    = ERR;
         ptr_upd    = 1'b0;
         cnt_d      = '0;
         ret_cnt_d  = '0;
         pipe_vld_d = '0;
      end
   end

   // Array and memory control decoded from state; forced low while reset is held
   always_comb begin
      way_sel        = '0;
      cache_comp     = 1'b0;
      cache_write    = 1'b0;
      cache_word     = '0;
      data_src       = DSRC_REQ;
      mem_rd         = 1'b0;
      mem_wr         = 1'b0;
      mem_word       = '0;
      mem_victim_tag = 1'b0;
      done           = 1'b0;
      hit            = 1'b0;
      err            = 1'b0;
      stall          = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               cache_comp  = 1'b1;
               cache_word  = req_offset;
               way_sel     = hit_onehot;
               cache_write = req & any_hit & req_wr;
            end
            HIT_DONE: begin
               done = 1'b1;
               hit  = 1'b1;
            end
            EVICT: begin
               way_sel        = victim_q;
               mem_wr         = 1'b1;
               mem_victim_tag = 1'b1;
               mem_word       = cnt_q[OFF_W-1:0];
               cache_word     = cnt_q[OFF_W-1:0];
            end
            FILL: begin
               way_sel  = victim_q;
               mem_rd   = (cnt_q != FULL);
               mem_word = cnt_q[OFF_W-1:0];
               if (ret_vld) begin
                  cache_write = 1'b1;
                  data_src    = DSRC_MEM;
                  cache_word  = ret_off;
               end
            end
            MERGE: begin
               way_sel     = victim_q;
               cache_comp  = 1'b1;
               cache_write = 1'b1;
               data_src    = DSRC_REQ;
               cache_word  = req_offset;
            end
            MISS_DONE: done = 1'b1;
            ERR: begin
               done = 1'b1;
               err  = 1'b1;
            end
            default: ;
         endcase
         stall = (state_q != IDLE) & ~done;
      end
   end

   // Controller state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ret_cnt_q  <= '0;
         victim_q   <= '0;
         vic_ptr_q  <= 1'b0;
         pipe_vld_q <= '0;
         pipe_off_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ret_cnt_q  <= ret_cnt_d;
         victim_q   <= victim_d;
         vic_ptr_q  <= vic_ptr_d;
         pipe_vld_q <= pipe_vld_d;
         pipe_off_q <= pipe_off_d;
      end
   end

`ifdef CACHE_CTRL_PERF_EN
   logic        evict_exit;
   logic [31:0] perf_hits_q, perf_hits_d;
   logic [31:0] perf_misses_q, perf_misses_d;
   logic [31:0] perf_wbacks_q, perf_wbacks_d;

   assign evict_exit = (state_q == EVICT) & ~mem_stall & (cnt_q == LAST) & ~err_in;

   // Saturating event counters
   always_comb begin
      perf_hits_d   = perf_hits_q;
      perf_misses_d = perf_misses_q;
      perf_wbacks_d = perf_wbacks_q;
      if ((state_q == HIT_DONE) && (perf_hits_q != '1))    perf_hits_d   = perf_hits_q + 32'd1;
      if ((state_q == MISS_DONE) && (perf_misses_q != '1)) perf_misses_d = perf_misses_q + 32'd1;
      if (evict_exit && (perf_wbacks_q != '1))             perf_wbacks_d = perf_wbacks_q + 32'd1;
   end

   // Counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_hits_q   <= '0;
         perf_misses_q <= '0;
         perf_wbacks_q <= '0;
      end else begin
         perf_hits_q   <= perf_hits_d;
         perf_misses_q <= perf_misses_d;
         perf_wbacks_q <= perf_wbacks_d;
      end
   end

   assign perf_hits   = perf_hits_q;
   assign perf_misses = perf_misses_q;
   assign perf_wbacks = perf_wbacks_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed testbench for cache_ctrl_assoc (2 ways, 256 sets, 4 words/line, latency 2).
// Inputs are driven 2 time units after the rising edge; outputs are checked 1 unit later.
// Expected values are hand-derived cycle counts relative to the request cycle.
module tb_cache_ctrl_assoc;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_rd, req_wr;
   logic [7:0] req_index;
   logic [1:0] req_offset;
   logic [1:0] way_hit, way_valid, way_dirty;
   logic       cache_err, mem_err, mem_stall;
   logic [1:0] way_sel;
   logic       cache_comp, cache_write;
   logic [1:0] cache_word;
   logic       data_src, mem_rd, mem_wr;
   logic [1:0] mem_word;
   logic       mem_victim_tag, done, hit, stall, err;
`ifdef CACHE_CTRL_PERF_EN
   logic [31:0] perf_hits, perf_misses, perf_wbacks;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cache_ctrl_assoc #(
      .NUM_WAYS(2), .NUM_SETS(256), .WORDS_PER_LINE(4), .MEM_LATENCY(2)
   ) dut (
      .clk(clk), .rst(rst),
      .req_rd(req_rd), .req_wr(req_wr), .req_index(req_index), .req_offset(req_offset),
      .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
      .cache_err(cache_err), .mem_err(mem_err), .mem_stall(mem_stall),
      .way_sel(way_sel), .cache_comp(cache_comp), .cache_write(cache_write),
      .cache_word(cache_word), .data_src(data_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_word(mem_word), .mem_victim_tag(mem_victim_tag),
      .done(done), .hit(hit), .stall(stall), .err(err)
`ifdef CACHE_CTRL_PERF_EN
     ,.perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbacks(perf_wbacks)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_index = '0; req_offset = '0;
      way_hit = '0; way_valid = '0; way_dirty = '0;
      cache_err = 1'b0; mem_err = 1'b0; mem_stall = 1'b0;

      // Reset: outputs stay low even with a hitting request present
      req_rd = 1'b1; way_hit = 2'b01; way_valid = 2'b01;
      #3;
      chk("rst_way_sel", 32'(way_sel), 0);
      chk("rst_comp",    32'(cache_comp), 0);
      chk("rst_stall",   32'(stall), 0);
      chk("rst_done",    32'(done), 0);
      cyc(); cyc();
      req_rd = 1'b0; way_hit = '0; way_valid = '0; rst = 1'b0;
      #1;
      chk("idle_comp",  32'(cache_comp), 1);
      chk("idle_stall", 32'(stall), 0);

      // Read hit in way 1
      cyc();
      req_rd = 1'b1; way_hit = 2'b10; way_valid = 2'b11; req_index = 8'd5; req_offset = 2'd1;
      #1;
      chk("rh_way_sel", 32'(way_sel), 2);
      chk("rh_cword",   32'(cache_word), 1);
      chk("rh_cwr",     32'(cache_write), 0);
      chk("rh_mem_rd",  32'(mem_rd), 0);
      cyc();
      chk("rh_done",  32'(done), 1);
      chk("rh_hit",   32'(hit), 1);
      chk("rh_stall", 32'(stall), 0);
      req_rd = 1'b0; way_hit = '0;
      cyc();
      chk("rh_idle_done", 32'(done), 0);

      // Write hit in way 0
      req_wr = 1'b1; way_hit = 2'b01; way_valid = 2'b11; req_offset = 2'd3;
      #1;
      chk("wh_cwr",     32'(cache_write), 1);
      chk("wh_way_sel", 32'(way_sel), 1);
      chk("wh_cword",   32'(cache_word), 3);
      cyc();
      chk("wh_done", 32'(done), 1);
      chk("wh_hit",  32'(hit), 1);
      req_wr = 1'b0; way_hit = '0;
      cyc();

      // Clean read miss, all ways invalid: victim way 0, done at cycle 7
      req_rd = 1'b1; req_index = 8'd7; req_offset = 2'd3; way_valid = 2'b00; way_dirty = 2'b00;
      #1;
      chk("cm_idle_mem_rd", 32'(mem_rd), 0);
      for (int c = 1; c <= 7; c++) begin
         cyc();
         chk("cm_mem_rd", 32'(mem_rd), 32'(c <= 4));
         if (c <= 4) chk("cm_mem_word", 32'(mem_word), 32'(c - 1));
         chk("cm_cwr", 32'(cache_write), 32'(c >= 3 && c <= 6));
         if (c >= 3 && c <= 6) begin
            chk("cm_cword",   32'(cache_word), 32'(c - 3));
            chk("cm_dsrc",    32'(data_src), 1);
            chk("cm_way_sel", 32'(way_sel), 1);
         end
         chk("cm_done",  32'(done), 32'(c == 7));
         chk("cm_stall", 32'(stall), 32'(c < 7));
      end
      chk("cm_hit", 32'(hit), 0);
      req_rd = 1'b0;
      cyc();

      // Dirty write miss, both ways dirty, pointer 0: evict way 0, fill, merge at offset 2
      req_wr = 1'b1; req_index = 8'd9; req_offset = 2'd2; way_valid = 2'b11; way_dirty = 2'b11;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         chk("dw_mem_wr", 32'(mem_wr), 32'(c <= 4));
         if (c <= 4) begin
            chk("dw_ev_word", 32'(mem_word), 32'(c - 1));
            chk("dw_ev_tag",  32'(mem_victim_tag), 1);
            chk("dw_ev_way",  32'(way_sel), 1);
            chk("dw_ev_comp", 32'(cache_comp), 0);
         end
         chk("dw_mem_rd", 32'(mem_rd), 32'(c >= 5 && c <= 8));
         if (c >= 5 && c <= 8) begin
            chk("dw_fi_word", 32'(mem_word), 32'(c - 5));
            chk("dw_fi_tag",  32'(mem_victim_tag), 0);
         end
         chk("dw_cwr", 32'(cache_write), 32'(c >= 7 && c <= 11));
         if (c == 11) begin
            chk("dw_mg_comp",  32'(cache_comp), 1);
            chk("dw_mg_dsrc",  32'(data_src), 0);
            chk("dw_mg_cword", 32'(cache_word), 2);
            chk("dw_mg_way",   32'(way_sel), 1);
         end
         chk("dw_done", 32'(done), 32'(c == 12));
      end
      chk("dw_hit", 32'(hit), 0);
      req_wr = 1'b0;
      cyc();

      // Dirty read miss, same set: pointer now selects way 1; 3-cycle stall mid-evict
      req_rd = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         cyc();
         if (c == 3) mem_stall = 1'b1;
         if (c == 6) mem_stall = 1'b0;
         #1;
         chk("st_mem_wr", 32'(mem_wr), 32'(c <= 7));
         if (c <= 7) begin
            chk("st_ev_word", 32'(mem_word), (c <= 2) ? 32'(c - 1) : ((c <= 6) ? 32'd2 : 32'd3));
            chk("st_ev_way",  32'(way_sel), 2);
         end
         chk("st_mem_rd", 32'(mem_rd), 32'(c >= 8 && c <= 11));
         if (c >= 8 && c <= 11) chk("st_fi_word", 32'(mem_word), 32'(c - 8));
         chk("st_cwr", 32'(cache_write), 32'(c >= 10 && c <= 13));
         if (c >= 10 && c <= 13) chk("st_cword", 32'(cache_word), 32'(c - 10));
         chk("st_done", 32'(done), 32'(c == 14));
      end
      req_rd = 1'b0;
      cyc();

      // Clean read miss via pointer (back to way 0); memory error during fill
      req_rd = 1'b1; way_dirty = 2'b00;
      cyc();
      chk("er_fill_way", 32'(way_sel), 1);
      chk("er_fill_rd",  32'(mem_rd), 1);
      cyc();
      mem_err = 1'b1;
      cyc();
      mem_err = 1'b0;
      #1;
      chk("er_done",  32'(done), 1);
      chk("er_err",   32'(err), 1);
      chk("er_hit",   32'(hit), 0);
      chk("er_stall", 32'(stall), 0);
      req_rd = 1'b0;
      cyc();
      chk("er_idle_done", 32'(done), 0);
      chk("er_idle_err",  32'(err), 0);

      // Retry: pointer unchanged, still way 0; reset mid-fill with returns in flight
      req_rd = 1'b1;
      cyc();
      chk("rs_fill_way", 32'(way_sel), 1);
      cyc();
      cyc();
      chk("rs_pre_cwr", 32'(cache_write), 1);
      rst = 1'b1;
      #1;
      chk("rs_mem_rd", 32'(mem_rd), 0);
      chk("rs_way",    32'(way_sel), 0);
      chk("rs_cwr",    32'(cache_write), 0);
      chk("rs_comp",   32'(cache_comp), 0);
      chk("rs_stall",  32'(stall), 0);
      cyc();
      rst = 1'b0;
      #1;
      chk("rs_rel_comp",  32'(cache_comp), 1);
      chk("rs_rel_stall", 32'(stall), 0);
      for (int k = 1; k <= 7; k++) begin
         cyc();
         chk("rs_cwr_after", 32'(cache_write), 32'(k >= 3 && k <= 6));
         if (k >= 3 && k <= 6) chk("rs_cword_after", 32'(cache_word), 32'(k - 3));
         chk("rs_mem_rd_after", 32'(mem_rd), 32'(k <= 4));
         chk("rs_done_after", 32'(done), 32'(k == 7));
      end
      req_rd = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_ctrl_assoc.md
Name: cache_ctrl_assoc

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache controller FSM. It succeeds the direct-mapped controller and adds configurable ways, line length and memory latency. It selects victims by first-invalid-then-round-robin and pipelines line write-back and fill against a stallable memory with fixed read latency. It sits between the processor memory stage and the banked four-word memory, driving the tag/data arrays and the memory request lines.

Parameters:
NUM_WAYS, 2, associativity; power of two, 1..8.
NUM_SETS, 256, sets per way; power of two.
WORDS_PER_LINE, 4, words per line; power of two, at least 2.
MEM_LATENCY, 2, cycles from an accepted mem_rd to its data being valid; at least 1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_rd  in  1  processor read request; held stable until done
req_wr  in  1  processor write request; held stable until done
req_index  in  clog2(NUM_SETS)  set index of the request
req_offset  in  clog2(WORDS_PER_LINE)  word offset of the request
way_hit  in  NUM_WAYS  per-way tag match
way_valid  in  NUM_WAYS  per-way valid bit
way_dirty  in  NUM_WAYS  per-way dirty bit
cache_err  in  1  array error
mem_err  in  1  memory error
mem_stall  in  1  memory cannot accept a request this cycle
way_sel  out  NUM_WAYS  one-hot way enable for the arrays
cache_comp  out  1  compare mode for the arrays
cache_write  out  1  array write strobe
cache_word  out  clog2(WORDS_PER_LINE)  array word offset
data_src  out  1  array write data source: 0 = request data, 1 = memory data
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
mem_word  out  clog2(WORDS_PER_LINE)  memory word offset
mem_victim_tag  out  1  1 = memory address uses the victim tag
done  out  1  one-cycle completion pulse
hit  out  1  qualifies done as a hit
stall  out  1  processor stall
err  out  1  error completion, asserted with done

Behaviour:
- Reset (async): state IDLE; every output 0; round-robin pointers 0; return pipe cleared. Reset mid-operation abandons the transaction and all in-flight reads.
- stall = (state != IDLE) & ~done.
- IDLE: cache_comp=1, cache_word=req_offset, way_sel=way_hit & way_valid.
  - On req_rd|req_wr with a hit in any way (lowest index wins): cache_write=req_wr; next state HIT_DONE.
  - On a miss: latch the victim way; next state EVICT if the victim is valid&dirty, else FILL.
- Victim selection: lowest-index invalid way; if none, ptr[req_index]. The pointer increments mod NUM_WAYS when FILL completes, and only if the victim came from the pointer.
- HIT_DONE: done=1, hit=1, then IDLE. Hit latency is 1 cycle.
- EVICT: cache_comp=0, way_sel=victim, mem_wr=1, mem_victim_tag=1, mem_word=cache_word=word counter.
  - The counter advances only when ~mem_stall.
  - After word WORDS_PER_LINE-1 is accepted, reset the counter and go to FILL.
- FILL issue side: mem_rd=1, mem_victim_tag=0, mem_word=issue counter; advances on ~mem_stall.
- FILL return side: a MEM_LATENCY-deep valid/offset shift pipe tracks accepted reads. When a return arrives: cache_write=1, cache_comp=0, data_src=1, cache_word=returned offset, way_sel=victim.
- Issue and return may occur in the same cycle.
- FILL exits when all WORDS_PER_LINE returns are written: req_wr goes to MERGE, otherwise to MISS_DONE.
- MERGE: cache_comp=1, cache_write=1, data_src=0, cache_word=req_offset, way_sel=victim; then MISS_DONE.
- MISS_DONE: done=1, hit=0; then IDLE.
- Error: cache_err or mem_err sampled high in any state other than IDLE-without-request goes to ERR. ERR: done=1, err=1, then IDLE. The pipe is flushed and the pointer is not updated.
- Miss latency with no stalls: 1 + (dirty ? W : 0) + W + MEM_LATENCY - 1 + (wr ? 1 : 0) + 1 cycles to done.

Optional Feature:
CACHE_CTRL_PERF_EN.
- Defined: adds outputs perf_hits, perf_misses, perf_wbacks (32 bits each). They are saturating counters, reset to 0, that increment on the HIT_DONE, MISS_DONE and EVICT-exit events respectively.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared header cache_pkg.vh: state encodings (IDLE, HIT_DONE, EVICT, FILL, MERGE, MISS_DONE, ERR), a clog2 function, and the data_src encodings.
- Sub-module cache_victim_sel: first-invalid priority encoder plus the NUM_SETS x clog2(NUM_WAYS) round-robin pointer table, with update strobe input.

Test Plan:
1. Read hit: way_hit=2'b10, way_valid=2'b11, req_rd=1 -> next cycle done=1, hit=1, way_sel=2'b10 in IDLE cycle, no mem_rd.
2. Clean read miss, all ways invalid, W=4, L=2 -> victim way0; mem_rd words 0..3 on 4 consecutive cycles; cache_write with data_src=1 on words 0..3 two cycles after each issue; done at cycle 7.
3. Dirty write miss, both ways valid and dirty, ptr=0 -> EVICT mem_wr words 0..3 with mem_victim_tag=1, then FILL, then MERGE at req_offset=2; done, hit=0; ptr[index] becomes 1.
4. mem_stall high for 3 cycles mid-EVICT -> mem_word holds, no word skipped or duplicated; total latency grows by exactly 3.
5. mem_err pulsed during FILL -> next cycle done=1, err=1; following IDLE request proceeds normally with ptr unchanged.
6. rst asserted mid-FILL with returns in flight -> outputs 0 immediately; after release, stale returns produce no cache_write.
